btn_debouncer: RTL and testbench

- Conditions raw pushbuttons before they reach the key checker's button receiver.
- Synchronises each raw button, debounces it with a per-button counter FSM, and emits one single-cycle press pulse per accepted press.
- Rejects chords, i.e. two or more buttons pressed together.
- Replaces the direct raw-button path into the receiver, so every guess digit comes from exactly one clean, isolated press.

---
 rtl/btn_debouncer.sv | 138 +++++++++++++
 tb/tb_btn_debouncer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debouncer.sv
// Pushbutton conditioner: synchronise, debounce, one-shot each press.
// Chorded presses are rejected and flagged on chord_err.
module btn_debouncer #(
  parameter int NUM_BTNS        = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_pulse,
  output logic                oneshotted_or,
  output logic                chord_err
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE_ST,
    PRESS_WAIT_ST,
    PRESSED_ST,
    RELEASE_WAIT_ST
  } state_t;

  logic [NUM_BTNS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_BTNS-1:0] s;
  logic [NUM_BTNS-1:0] qual;
  logic [NUM_BTNS-1:0] held;
  logic [NUM_BTNS-1:0] lvl_d;
  logic [NUM_BTNS-1:0] pulse_d;
  logic                single;
  logic                accept;
  logic                chord_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= '0;
      end
    end else begin
      sync_q[0] <= btn_raw;
      for (int j = 1; j < SYNC_STAGES; j++) begin
        sync_q[j] <= sync_q[j-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          qual_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE_ST;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      qual_d  = 1'b0;
      unique case (state_q)
        IDLE_ST: begin
          if (s[i]) begin
            state_d = PRESS_WAIT_ST;
            cnt_d   = CNT_ONE;
          end
        end
        PRESS_WAIT_ST: begin
          if (!s[i]) begin
            state_d = IDLE_ST;
          end else if (cnt_q == CNT_MAX) begin
            state_d = PRESSED_ST;
            qual_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        PRESSED_ST: begin
          if (!s[i]) begin
            state_d = RELEASE_WAIT_ST;
            cnt_d   = CNT_ONE;
          end
        end
        RELEASE_WAIT_ST: begin
          if (s[i]) begin
            state_d = PRESSED_ST;
          end else if (cnt_q == CNT_MAX) begin
            state_d = IDLE_ST;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE_ST;
      endcase
    end

    assign qual[i]  = qual_d;
    assign held[i]  = (state_q == PRESSED_ST) ||
                      (state_q == RELEASE_WAIT_ST);
    assign lvl_d[i] = (state_d == PRESSED_ST) ||
                      (state_d == RELEASE_WAIT_ST);
  end

  // A lone qualifying press is only accepted if no other button is down.
  assign single  = (|qual) &&
                   ((qual & (qual - NUM_BTNS'(1))) == '0);
  assign accept  = single && !(|held);
  assign pulse_d = accept ? qual : '0;
  assign chord_d = (|qual) && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level <= '0;
      btn_pulse <= '0;
      chord_err <= 1'b0;
    end else begin
      btn_level <= lvl_d;
      btn_pulse <= pulse_d;
      chord_err <= chord_d;
    end
  end

  assign oneshotted_or = |btn_pulse;

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with a 4-cycle debounce window.
// Expected timings are counted in clock edges from the first sampling edge.
module tb_btn_debouncer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn_raw = 3'b000;
  logic [2:0] btn_level;
  logic [2:0] btn_pulse;
  logic       oneshotted_or;
  logic       chord_err;

  int checks = 0;
  int errors = 0;
  int pcnt [3];
  int ccnt = 0;
  int bad = 0;
  logic [2:0] prev_pulse = 3'b000;

  always #5 clk = ~clk;

  btn_debouncer #(
    .NUM_BTNS(3),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .oneshotted_or(oneshotted_or),
    .chord_err(chord_err)
  );

  initial begin
    for (int i = 0; i < 3; i++) pcnt[i] = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (btn_pulse[i]) pcnt[i] <= pcnt[i] + 1;
    end
    if (chord_err) ccnt <= ccnt + 1;
    if ((oneshotted_or !== (|btn_pulse)) ||
        ($countones(btn_pulse) > 1) ||
        ((prev_pulse & btn_pulse) != 3'b000))
      bad <= bad + 1;
    prev_pulse <= btn_pulse;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int acc;

  initial begin
    // 1: reset with all buttons high, release with buttons low
    rst_n   = 1'b0;
    btn_raw = 3'b111;
    acc = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      acc += int'(btn_level) + int'(btn_pulse) +
             int'(chord_err) + int'(oneshotted_or);
    end
    chk("t1_rst_outs", acc, 0);
    btn_raw = 3'b000;
    rst_n   = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      acc += int'(btn_level) + int'(btn_pulse) + int'(chord_err);
    end
    chk("t1_post_rst", acc, 0);

    // 2: clean press on button 0
    btn_raw = 3'b001;
    repeat (5) tick();
    chk("t2_pulse_early", int'(btn_pulse), 0);
    chk("t2_lvl_early", int'(btn_level), 0);
    tick();
    chk("t2_pulse", int'(btn_pulse), 1);
    chk("t2_or", int'(oneshotted_or), 1);
    chk("t2_lvl", int'(btn_level), 1);
    tick();
    chk("t2_pulse_end", int'(btn_pulse), 0);
    chk("t2_or_end", int'(oneshotted_or), 0);
    repeat (13) tick();
    btn_raw = 3'b000;
    repeat (5) tick();
    chk("t2_lvl_hold", int'(btn_level), 1);
    tick();
    chk("t2_lvl_rel", int'(btn_level), 0);
    chk("t2_pcnt0", pcnt[0], 1);

    // 3: bouncing press and release on button 1
    btn_raw = 3'b010; tick(); tick();
    btn_raw = 3'b000; tick();
    btn_raw = 3'b010; tick();
    btn_raw = 3'b000; tick();
    btn_raw = 3'b010;
    repeat (5) tick();
    chk("t3_pulse_early", int'(btn_pulse), 0);
    tick();
    chk("t3_pulse", int'(btn_pulse), 2);
    repeat (9) tick();
    acc = 0;
    btn_raw = 3'b000; tick(); acc += int'(!btn_level[1]);
    tick(); acc += int'(!btn_level[1]);
    btn_raw = 3'b010; tick(); acc += int'(!btn_level[1]);
    btn_raw = 3'b000; tick(); acc += int'(!btn_level[1]);
    btn_raw = 3'b010; tick(); acc += int'(!btn_level[1]);
    btn_raw = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      acc += int'(!btn_level[1]);
    end
    chk("t3_bounce_lvl", acc, 0);
    tick();
    chk("t3_lvl_rel", int'(btn_level), 0);
    chk("t3_pcnt1", pcnt[1], 1);

    // 4: three-cycle glitch on button 2
    acc = 0;
    btn_raw = 3'b100;
    for (int i = 0; i < 3; i++) begin
      tick();
      acc += int'(btn_level) + int'(btn_pulse) + int'(chord_err);
    end
    btn_raw = 3'b000;
    for (int i = 0; i < 10; i++) begin
      tick();
      acc += int'(btn_level) + int'(btn_pulse) + int'(chord_err);
    end
    chk("t4_glitch", acc, 0);
    chk("t4_pcnt2", pcnt[2], 0);

    // 5a: button 2 pressed while button 0 held
    btn_raw = 3'b001;
    repeat (6) tick();
    chk("t5a_p0", int'(btn_pulse), 1);
    chk("t5a_lvl0", int'(btn_level), 1);
    btn_raw = 3'b101;
    repeat (5) tick();
    chk("t5a_chord_early", int'(chord_err), 0);
    tick();
    chk("t5a_chord", int'(chord_err), 1);
    chk("t5a_nopulse", int'(btn_pulse), 0);
    chk("t5a_lvl", int'(btn_level), 5);
    tick();
    chk("t5a_chord_end", int'(chord_err), 0);
    btn_raw = 3'b000;
    repeat (10) tick();
    chk("t5a_lvl_rel", int'(btn_level), 0);
    chk("t5a_pcnt0", pcnt[0], 2);
    chk("t5a_pcnt2", pcnt[2], 0);
    chk("t5a_ccnt", ccnt, 1);

    // 5b: simultaneous press of buttons 0 and 1
    btn_raw = 3'b011;
    repeat (6) tick();
    chk("t5b_chord", int'(chord_err), 1);
    chk("t5b_nopulse", int'(btn_pulse), 0);
    chk("t5b_lvl", int'(btn_level), 3);
    tick();
    chk("t5b_chord_end", int'(chord_err), 0);
    btn_raw = 3'b000;
    repeat (10) tick();
    chk("t5b_pcnt0", pcnt[0], 2);
    chk("t5b_pcnt1", pcnt[1], 1);
    chk("t5b_ccnt", ccnt, 2);

    // 6a: reset while button 0 is mid-debounce
    btn_raw = 3'b001;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("t6a_rst_outs", int'(btn_level) + int'(btn_pulse), 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t6a_pulse_early", int'(btn_pulse), 0);
    tick();
    chk("t6a_pulse", int'(btn_pulse), 1);
    tick();
    chk("t6a_pcnt0", pcnt[0], 3);

    // 6b: reset while button 0 level is high
    chk("t6b_lvl_pre", int'(btn_level), 1);
    rst_n = 1'b0;
    #1;
    chk("t6b_lvl_rst", int'(btn_level), 0);
    btn_raw = 3'b000;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("t6b_lvl_post", int'(btn_level), 0);
    chk("t6b_pcnt0", pcnt[0], 3);

    chk("mon_pulse_rules", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
